// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between instruction fetch and data load/store requesters.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration on contention (default: data beats fetch).
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   i_req/i_addr              fetch request and address, held until i_gnt
//   i_gnt/i_rvalid/i_rdata    fetch accept, one-cycle read-data pulse, held fetch data
//   d_req/d_we/d_addr/d_wdata/d_len  data request and payload, held until d_gnt
//   d_gnt/d_rvalid/d_rdata    data accept, one-cycle load-data pulse, held load data
//   m_en/m_we/m_addr/m_wdata/m_len   memory command port
//   m_rdata                   memory read data, valid RD_LATENCY cycles after the m_en cycle
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [1:0]        d_len,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [1:0]        m_len,
  input  logic [DATA_W-1:0] m_rdata
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state;
  logic [3:0] cnt;
  logic owner_d;
  logic [ADDR_W-1:0] last_addr;
  logic pick_d;
`ifdef MEM_ARB_RR_EN
  // 1 = data side won the most recent grant; resets as if fetch won last so data leads the first contention
  logic rr_last;
  always_comb pick_d = d_req && (!i_req || !rr_last);
`else
  always_comb pick_d = d_req;
`endif
  always_comb begin
    d_gnt = state == IDLE && !rst && pick_d;
    i_gnt = state == IDLE && !rst && i_req && !pick_d;
    m_en = d_gnt || i_gnt;
    m_we = d_gnt && d_we;
    m_addr = d_gnt ? d_addr : i_gnt ? i_addr : last_addr;
    m_wdata = d_gnt ? d_wdata : '0;
    m_len = d_gnt ? d_len : 2'b00;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      owner_d <= 1'b1;
      last_addr <= '0;
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
`ifdef MEM_ARB_RR_EN
      rr_last <= 1'b0;
`endif
    end else begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      if (m_en) last_addr <= m_addr;
`ifdef MEM_ARB_RR_EN
      if (m_en) rr_last <= d_gnt;
`endif
      if (state == IDLE) begin
        if (m_en && !m_we) begin
          state <= WAIT;
          owner_d <= d_gnt;
          cnt <= 4'(RD_LATENCY);
        end
      end else begin
        cnt <= cnt - 4'd1;
        // cnt == 1 marks the cycle in which m_rdata carries the outstanding read
        if (cnt == 4'd1) begin
          state <= IDLE;
          if (owner_d) begin
            d_rvalid <= 1'b1;
            d_rdata <= m_rdata;
          end else begin
            i_rvalid <= 1'b1;
            i_rdata <= m_rdata;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: checks two arbiters (RD_LATENCY 1 and 3) against a cycle-count reference model.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  logic [1:0] i_req, d_req, d_we, i_gnt, i_rvalid, d_gnt, d_rvalid, m_en, m_we;
  logic [1:0][31:0] i_addr, d_addr, d_wdata, i_rdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic [1:0][1:0] d_len, m_len;
  int ncmp = 0, nfail = 0, cyc = 0, mode = 0;
  int free_at[2], i_due[2], d_due[2];
  int n_ig[2], n_dg[2], n_iv[2], n_dv[2], c_ig[2], c_dg[2], c_iv[2], c_dv[2];
  logic [31:0] i_pend[2], d_pend[2], i_exp[2], d_exp[2], last_a[2];
  logic sg_i[2], sg_d[2];
  int t, r, a0, b0, a1, b1;
  function automatic logic [31:0] memval(input logic [31:0] a);
    return (a == 32'h100) ? 32'h00500093 : (a * 32'h9E3779B1) ^ 32'h0000_1234;
  endfunction
  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [31:0] pipe[4];
    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(g ? 3 : 1)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req[g]), .i_addr(i_addr[g]), .i_gnt(i_gnt[g]), .i_rvalid(i_rvalid[g]), .i_rdata(i_rdata[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]), .d_len(d_len[g]),
      .d_gnt(d_gnt[g]), .d_rvalid(d_rvalid[g]), .d_rdata(d_rdata[g]),
      .m_en(m_en[g]), .m_we(m_we[g]), .m_addr(m_addr[g]), .m_wdata(m_wdata[g]), .m_len(m_len[g]),
      .m_rdata(m_rdata[g]));
    always @(posedge clk) begin
      pipe[0] <= (m_en[g] && !m_we[g]) ? memval(m_addr[g]) : 32'hBAD0BAD0;
      for (int j = 1; j < 4; j++) pipe[j] <= pipe[j-1];
    end
    assign m_rdata[g] = pipe[g ? 2 : 0];
  end
  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s[%0d] cyc=%0d observed=%h expected=%h", tag, k, cyc, obs, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      int lat = k ? 3 : 1;
      logic wd, wi;
      if (rst) begin
        free_at[k] = cyc + 1;
        i_due[k] = -1;
        d_due[k] = -1;
        i_exp[k] = '0;
        d_exp[k] = '0;
        last_a[k] = '0;
      end
      if (i_due[k] == cyc) i_exp[k] = i_pend[k];
      if (d_due[k] == cyc) d_exp[k] = d_pend[k];
      wd = !rst && cyc >= free_at[k] && d_req[k];
      wi = !rst && cyc >= free_at[k] && i_req[k] && !d_req[k];
      chk("d_gnt", k, d_gnt[k], wd);
      chk("i_gnt", k, i_gnt[k], wi);
      chk("m_en", k, m_en[k], wd || wi);
      if (wd || wi) begin
        chk("m_we", k, m_we[k], wd && d_we[k]);
        chk("m_addr", k, m_addr[k], wd ? d_addr[k] : i_addr[k]);
        chk("m_wdata", k, m_wdata[k], wd ? d_wdata[k] : 32'h0);
        chk("m_len", k, m_len[k], wd ? d_len[k] : 2'b00);
      end else if (cyc < free_at[k]) begin
        chk("m_addr_hold", k, m_addr[k], last_a[k]);
        chk("m_we_wait", k, m_we[k], 1'b0);
        chk("m_wdata_wait", k, m_wdata[k], 32'h0);
        chk("m_len_wait", k, m_len[k], 2'b00);
      end
      chk("i_rvalid", k, i_rvalid[k], i_due[k] == cyc);
      chk("d_rvalid", k, d_rvalid[k], d_due[k] == cyc);
      chk("i_rdata", k, i_rdata[k], i_exp[k]);
      chk("d_rdata", k, d_rdata[k], d_exp[k]);
      sg_i[k] = i_gnt[k];
      sg_d[k] = d_gnt[k];
      if (i_gnt[k]) begin n_ig[k]++; c_ig[k] = cyc; end
      if (d_gnt[k]) begin n_dg[k]++; c_dg[k] = cyc; end
      if (i_rvalid[k]) begin n_iv[k]++; c_iv[k] = cyc; end
      if (d_rvalid[k]) begin n_dv[k]++; c_dv[k] = cyc; end
      if (wd || wi) begin
        last_a[k] = wd ? d_addr[k] : i_addr[k];
        if (wd && d_we[k]) free_at[k] = cyc + 1;
        else begin
          free_at[k] = cyc + lat + 1;
          if (wd) begin d_due[k] = cyc + lat + 1; d_pend[k] = memval(d_addr[k]); end
          else begin i_due[k] = cyc + lat + 1; i_pend[k] = memval(i_addr[k]); end
        end
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int k = 0; k < 2; k++) begin
      if (mode != 1) begin
        if (sg_i[k]) i_req[k] = 1'b0;
        if (sg_d[k]) d_req[k] = 1'b0;
      end
      if (mode == 2) begin
        if (!i_req[k] && $urandom_range(0, 2) != 0) begin
          i_req[k] = 1'b1;
          i_addr[k] = $urandom & 32'hFFFF_FFFC;
        end
        if (!d_req[k] && $urandom_range(0, 2) != 0) begin
          d_req[k] = 1'b1;
          d_we[k] = 1'($urandom_range(0, 1));
          d_addr[k] = $urandom;
          d_wdata[k] = $urandom;
          d_len[k] = 2'($urandom_range(0, 3));
        end
      end
    end
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      i_req[k] = 1'b1; i_addr[k] = 32'h40;
      d_req[k] = 1'b1; d_we[k] = 1'b0; d_addr[k] = 32'h80; d_wdata[k] = '0; d_len[k] = 2'b00;
    end
    ticks(2);
    rst = 1'b0;
    r = cyc;
    tick();
    chk("rst_first_dgnt_cyc", 0, c_dg[0], r);
    chk("rst_first_dgnt_cyc", 1, c_dg[1], r);
    ticks(12);
    a0 = n_dv[0]; a1 = n_dv[1];
    for (int k = 0; k < 2; k++) begin i_req[k] = 1'b1; i_addr[k] = 32'h100; end
    t = cyc;
    ticks(6);
    chk("fetch_gnt_cyc", 0, c_ig[0], t);
    chk("fetch_rvalid_cyc", 0, c_iv[0], t + 2);
    chk("fetch_rvalid_cyc", 1, c_iv[1], t + 4);
    chk("fetch_rdata", 0, i_rdata[0], 32'h00500093);
    chk("fetch_rdata", 1, i_rdata[1], 32'h00500093);
    chk("fetch_no_drvalid", 0, n_dv[0], a0);
    chk("fetch_no_drvalid", 1, n_dv[1], a1);
    for (int k = 0; k < 2; k++) begin
      d_req[k] = 1'b1; d_we[k] = 1'b0; d_addr[k] = 32'h300;
      i_req[k] = 1'b1; i_addr[k] = 32'h104;
    end
    t = cyc;
    ticks(10);
    for (int k = 0; k < 2; k++) begin
      chk("cont_dgnt", k, c_dg[k], t);
      chk("cont_drvalid", k, c_dv[k], t + (k ? 4 : 2));
      chk("cont_ignt", k, c_ig[k], t + (k ? 4 : 2));
      chk("cont_irvalid", k, c_iv[k], t + (k ? 8 : 4));
    end
    a0 = n_dv[0]; a1 = n_dv[1];
    for (int k = 0; k < 2; k++) begin
      d_req[k] = 1'b1; d_we[k] = 1'b1; d_addr[k] = 32'h200; d_wdata[k] = 32'hDEADBEEF; d_len[k] = 2'b10;
      i_req[k] = 1'b1; i_addr[k] = 32'h108;
    end
    t = cyc;
    ticks(8);
    for (int k = 0; k < 2; k++) begin
      chk("store_dgnt", k, c_dg[k], t);
      chk("store_then_ignt", k, c_ig[k], t + 1);
    end
    chk("store_no_drvalid", 0, n_dv[0], a0);
    chk("store_no_drvalid", 1, n_dv[1], a1);
    d_we = '0;
    d_req[1] = 1'b1; d_addr[1] = 32'h400;
    b1 = n_dv[1];
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    i_req[1] = 1'b1; i_addr[1] = 32'h500;
    r = cyc;
    tick();
    chk("post_rst_ignt", 1, c_ig[1], r);
    ticks(6);
    chk("rst_drops_drvalid", 1, n_dv[1], b1);
    chk("post_rst_irvalid", 1, c_iv[1], r + 4);
    mode = 1;
    a0 = n_dg[0]; b0 = n_ig[0]; a1 = n_dg[1]; b1 = n_ig[1];
    for (int k = 0; k < 2; k++) begin
      d_req[k] = 1'b1; d_we[k] = 1'b0; d_addr[k] = 32'h600;
      i_req[k] = 1'b1; i_addr[k] = 32'h700;
    end
    ticks(32);
    chk("hold_d_grants", 0, n_dg[0] - a0, 16);
    chk("hold_i_grants", 0, n_ig[0] - b0, 0);
    chk("hold_d_grants", 1, n_dg[1] - a1, 8);
    chk("hold_i_grants", 1, n_ig[1] - b1, 0);
    mode = 0;
    i_req = '0; d_req = '0;
    ticks(8);
    mode = 2;
    ticks(800);
    mode = 0;
    i_req = '0; d_req = '0;
    ticks(10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
